sync_vga: RTL
=============

// Module: sync_vga
// PURPOSE
//  Raster timing stage directly upstream of the picture generator: produces pixel_x, pixel_y and video_on that index the image ROMs.
//  Also drives hsync/vsync for the VGA connector. Standard 640x480@60 Hz, 25 MHz pixel rate from the 100 MHz board clock (Nexys 3).
//  p_tick and frame_tick go to downstream logic: the RGB output register and the ring-blink counter.
// PARAMETERS
//  DIV      4    clk cycles per pixel; >=1; 4 gives 25 MHz from 100 MHz
//  HD       640  horizontal visible pixels
//  HF       16   horizontal front porch
//  HR       96   hsync pulse width
//  HB       48   horizontal back porch
//  VD       480  visible lines
//  VF       10   vertical front porch
//  VR       2    vsync pulse width
//  VB       33   vertical back porch
// PORTS
//  clk         in   1   system clock, 100 MHz
//  reset       in   1   synchronous, active-high
//  hsync       out  1   horizontal sync, active low, registered
//  vsync       out  1   vertical sync, active low, registered
//  video_on    out  1   1 when pixel_x<HD and pixel_y<VD
//  p_tick      out  1   1-clk pulse, once every DIV clks; counters advance on it
//  frame_tick  out  1   1-clk pulse on the p_tick that wraps both counters to (0,0)
//  pixel_x     out  10  horizontal count, 0..H_TOT-1, with H_TOT=HD+HF+HR+HB=800
//  pixel_y     out  10  vertical count, 0..V_TOT-1, with V_TOT=VD+VF+VR+VB=525
// BEHAVIOUR
//  Reset (sampled on clk rising edge) sets: div_cnt=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1.
//   Reset asserted mid-frame returns all of these to the reset values on the next edge; no partial line completes.
//  div_cnt counts 0..DIV-1 and wraps.
//   p_tick = (div_cnt==DIV-1), decoded combinationally from the register.
//   With DIV=1, p_tick is constantly 1.
//   With DIV=4, the first p_tick is high in the 4th clk after reset is released (div_cnt=3).
//  On a clk edge with p_tick=1:
//   pixel_x==H_TOT-1: pixel_x<=0, and pixel_y<=(pixel_y==V_TOT-1) ? 0 : pixel_y+1.
//   otherwise: pixel_x<=pixel_x+1 and pixel_y holds.
//  With p_tick=0, all counters and syncs hold.
//  hsync/vsync are registered from the NEXT counter values, so they are aligned with pixel_x/pixel_y in the same cycle (0-clk skew):
//   hsync=0 iff HD+HF <= pixel_x <= HD+HF+HR-1, i.e. 656..751
//   vsync=0 iff VD+VF <= pixel_y <= VD+VF+VR-1, i.e. 490..491
//  video_on: combinational from the registered counters; low during porches and sync.
//  frame_tick = p_tick && pixel_x==H_TOT-1 && pixel_y==V_TOT-1.
//  Widths:
//   counters are 10 bits; H_TOT and V_TOT must be <=1024;
//   div_cnt width is $clog2(DIV), minimum 1 bit.
//  Frame period = DIV*H_TOT*V_TOT clks = 1,680,000 at the defaults.
//  No other state. Outputs never glitch: syncs are flop outputs.
// TESTING
//  1) Reset 3 clks, release: pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=1; p_tick pulses at clk 3, 7, 11 after release.
//  2) Run 1 line: pixel_x steps 0..799 then 0, and pixel_y goes 0->1 on the wrap edge; hsync low for exactly 96 p_ticks starting when pixel_x=656.
//  3) Run 1 full frame: vsync low exactly while pixel_y in {490,491} (1600 p_ticks); frame_tick fires once, at (799,524); period = 1,680,000 clks.
//  4) video_on check: 1 at (639,479), 0 at (640,0), 0 at (0,480), 1 at (0,0).
//  5) Assert reset at pixel (700,300), mid-hsync: the next edge gives pixel_x=0, pixel_y=0, hsync=1, div_cnt=0; normal sequence resumes.
//  6) Re-elaborate with DIV=1: p_tick is always 1 and pixel_x increments every clk; frame period = 420,000 clks.

Source files
------------

// File: rtl/sync_vga_if.sv
// Raster timing bundle from the VGA sync stage to the picture generator and connector.
// The master drives the raster position and strobes; the slave consumes them.
interface sync_vga_if;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       p_tick;
   logic       frame_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;

   modport master (
      output hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
   );

   modport slave (
      input  hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
   );
endinterface

// File: rtl/sync_vga.sv
// Raster timing generator: pixel-rate divider, horizontal/vertical counters and
// registered active-low syncs aligned with the counters they are decoded from.
module sync_vga #(
   parameter int DIV = 4,
   parameter int HD  = 640,
   parameter int HF  = 16,
   parameter int HR  = 96,
   parameter int HB  = 48,
   parameter int VD  = 480,
   parameter int VF  = 10,
   parameter int VR  = 2,
   parameter int VB  = 33
) (
   input  logic         clk,
   input  logic         reset,
   sync_vga_if.master   vga
);
   localparam int H_TOT = HD + HF + HR + HB;
   localparam int V_TOT = VD + VF + VR + VB;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0]    H_VIS    = 10'(HD);
   localparam logic [9:0]    V_VIS    = 10'(VD);
   localparam logic [9:0]    HS_BEG   = 10'(HD + HF);
   localparam logic [9:0]    HS_END   = 10'(HD + HF + HR - 1);
   localparam logic [9:0]    VS_BEG   = 10'(VD + VF);
   localparam logic [9:0]    VS_END   = 10'(VD + VF + VR - 1);

   logic [DW-1:0] r_div_cnt;
   logic [9:0]    r_x;
   logic [9:0]    r_y;
   logic          r_hsync;
   logic          r_vsync;

   logic          w_p_tick;
   logic [9:0]    w_x_next;
   logic [9:0]    w_y_next;

   assign w_p_tick = (r_div_cnt == DIV_LAST);

   always_comb begin
      w_x_next = r_x;
      w_y_next = r_y;
      if (w_p_tick) begin
         if (r_x == H_LAST) begin
            w_x_next = '0;
            w_y_next = (r_y == V_LAST) ? '0 : r_y + 10'd1;
         end else begin
            w_x_next = r_x + 10'd1;
         end
      end
   end

   // Syncs decode the next counter values so they change on the same edge as the counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
      end else begin
         r_div_cnt <= w_p_tick ? '0 : r_div_cnt + 1'b1;
         r_x       <= w_x_next;
         r_y       <= w_y_next;
         r_hsync   <= !((w_x_next >= HS_BEG) && (w_x_next <= HS_END));
         r_vsync   <= !((w_y_next >= VS_BEG) && (w_y_next <= VS_END));
      end
   end

   assign vga.hsync      = r_hsync;
   assign vga.vsync      = r_vsync;
   assign vga.video_on   = (r_x < H_VIS) && (r_y < V_VIS);
   assign vga.p_tick     = w_p_tick;
   assign vga.frame_tick = w_p_tick && (r_x == H_LAST) && (r_y == V_LAST);
   assign vga.pixel_x    = r_x;
   assign vga.pixel_y    = r_y;
endmodule
